idex_buffer: RTL

- Decode/execute pipeline register. It sits directly upstream of the execute-memory stage and feeds it every operand, control and PC field for one instruction.
- It also sequences the two execute cycles needed by 32-bit PC push/pop (CALL/RET/INT/RTI) through o_hazard_state, and stalls decode during the first cycle.
- It squashes instructions into bubbles on flush or load-use stall.

---
 rtl/idex_if.sv | 49 ++++
 rtl/idex_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/idex_if.sv
// Decode -> execute bundle for the ID/EX pipeline register.
// master: the decode side (drives i_* fields, observes o_* fields).
// slave:  the ID/EX register itself.
interface idex_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 24
);
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data1;
  logic [DATA_W-1:0] i_data2;
  logic [DATA_W-1:0] i_immediate;
  logic [DATA_W-1:0] i_sh_amount;
  logic [2:0]        i_rd;
  logic [2:0]        i_rs;
  logic [2:0]        i_write_addr;
  logic [PC_W-1:0]   i_pc;
  logic              i_flush;
  logic              i_stall;

  logic [CTRL_W-1:0] o_ctrl;
  logic [DATA_W-1:0] o_data1;
  logic [DATA_W-1:0] o_data2;
  logic [DATA_W-1:0] o_immediate;
  logic [DATA_W-1:0] o_sh_amount;
  logic [2:0]        o_rd;
  logic [2:0]        o_rs;
  logic [2:0]        o_write_addr;
  logic [PC_W-1:0]   o_pc;
  logic              o_hazard_state;
  logic              o_stall_upstream;
  logic [15:0]       o_bubble_count;

  modport master (
    output i_ctrl, i_data1, i_data2, i_immediate, i_sh_amount,
           i_rd, i_rs, i_write_addr, i_pc, i_flush, i_stall,
    input  o_ctrl, o_data1, o_data2, o_immediate, o_sh_amount,
           o_rd, o_rs, o_write_addr, o_pc, o_hazard_state,
           o_stall_upstream, o_bubble_count
  );

  modport slave (
    input  i_ctrl, i_data1, i_data2, i_immediate, i_sh_amount,
           i_rd, i_rs, i_write_addr, i_pc, i_flush, i_stall,
    output o_ctrl, o_data1, o_data2, o_immediate, o_sh_amount,
           o_rd, o_rs, o_write_addr, o_pc, o_hazard_state,
           o_stall_upstream, o_bubble_count
  );
endinterface

// File: rtl/idex_buffer.sv
// ID/EX pipeline register with a two-cycle sequencer for PC push/pop ops
// (CALL/RET/INT/RTI) and bubble insertion on flush or load-use stall.
// Optional macro IDEX_BUBBLE_COUNT_EN adds a saturating 16-bit bubble counter;
// without it o_bubble_count is tied to zero.
module idex_buffer #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int CTRL_W = 24
) (
  input logic   i_clk,
  input logic   i_reset,
  idex_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              pending_flush;
  logic              two_cycle;
  logic              load;
  logic              bubble;
  logic              stall_upstream;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data2_q;
  logic [DATA_W-1:0] immediate_q;
  logic [DATA_W-1:0] sh_amount_q;
  logic [2:0]        rd_q;
  logic [2:0]        rs_q;
  logic [2:0]        write_addr_q;
  logic [PC_W-1:0]   pc_q;

  // pop_pc or push_pc in the held instruction means it needs a second execute cycle
  assign two_cycle = ctrl_q[2] | ctrl_q[1];

  // Sequencer decode: hold during the first cycle of a two-cycle op, load otherwise
  always_comb begin
    next_state     = state;
    load           = 1'b0;
    bubble         = 1'b0;
    stall_upstream = 1'b0;
    case (state)
      IDLE: begin
        if (two_cycle) begin
          stall_upstream = 1'b1;
          next_state     = SECOND;
        end else begin
          load   = 1'b1;
          bubble = bus.i_flush | bus.i_stall;
        end
      end
      SECOND: begin
        next_state = IDLE;
        load       = 1'b1;
        bubble     = pending_flush | bus.i_flush | bus.i_stall;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= next_state;
  end

  // Remember a flush/stall that arrived while the register was held; it squashes the next load
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) pending_flush <= 1'b0;
    else          pending_flush <= (state == IDLE) && two_cycle && (bus.i_flush | bus.i_stall);
  end

  // Pipeline fields: capture, squash to an all-zero bubble, or hold
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      immediate_q  <= '0;
      sh_amount_q  <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      write_addr_q <= '0;
      pc_q         <= '0;
    end else if (load) begin
      if (bubble) begin
        ctrl_q       <= '0;
        data1_q      <= '0;
        data2_q      <= '0;
        immediate_q  <= '0;
        sh_amount_q  <= '0;
        rd_q         <= '0;
        rs_q         <= '0;
        write_addr_q <= '0;
        pc_q         <= '0;
      end else begin
        ctrl_q       <= bus.i_ctrl;
        data1_q      <= bus.i_data1;
        data2_q      <= bus.i_data2;
        immediate_q  <= bus.i_immediate;
        sh_amount_q  <= bus.i_sh_amount;
        rd_q         <= bus.i_rd;
        rs_q         <= bus.i_rs;
        write_addr_q <= bus.i_write_addr;
        pc_q         <= bus.i_pc;
      end
    end
  end

`ifdef IDEX_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;

  // Count every bubble load, sticking at all-ones
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                                    bubble_count <= '0;
    else if (load && bubble && bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
  end

  assign bus.o_bubble_count = bubble_count;
`else
  assign bus.o_bubble_count = 16'd0;
`endif

  assign bus.o_ctrl           = ctrl_q;
  assign bus.o_data1          = data1_q;
  assign bus.o_data2          = data2_q;
  assign bus.o_immediate      = immediate_q;
  assign bus.o_sh_amount      = sh_amount_q;
  assign bus.o_rd             = rd_q;
  assign bus.o_rs             = rs_q;
  assign bus.o_write_addr     = write_addr_q;
  assign bus.o_pc             = pc_q;
  assign bus.o_hazard_state   = (state == SECOND);
  assign bus.o_stall_upstream = stall_upstream;

endmodule
